// File: rtl/uart_baud_gen_pkg.sv
// uart_pkg: baud-rate table, divisor helper and shared types for the
// fractional-N baud generator.
package uart_pkg;

  typedef logic [3:0] baud_sel_t;

  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } div_t;

  localparam int unsigned BAUD_RATES [16] = '{
    200, 300, 600, 1200, 2400, 4800, 9600, 14400,
    19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800
  };

  // D = round_half_up(clk * 2^fb / (baud * os)), split into {I, F}.
  function automatic div_t calc_div(input longint unsigned clk,
                                    input longint unsigned baud,
                                    input longint unsigned os,
                                    input int unsigned     fb);
    longint unsigned den;
    longint unsigned d;
    div_t            r;
    den         = baud * os;
    d           = ((clk << fb) + den / 2) / den;
    r.int_part  = 32'(d >> fb);
    r.frac_part = 32'(d & ((64'd1 << fb) - 64'd1));
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: configuration inputs and tick outputs of uart_baud_gen.
// Build option UART_CUSTOM_DIV_EN adds use_custom / custom_div_tx / custom_div_rx.
interface uart_baud_gen_if #(
  parameter int unsigned OVERSAMPLE = 16
`ifdef UART_CUSTOM_DIV_EN
  , parameter int unsigned DIV_W     = 20
  , parameter int unsigned FRAC_BITS = 4
`endif
);
  import uart_pkg::*;

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  // No valid/ready here: every tick output is a single-cycle strobe with no
  // back-pressure, and configuration (baud_sel, use_custom, custom_div_*) is
  // only sampled while active is low; rx_resync is a one-cycle request.
  logic            active;
  baud_sel_t       baud_sel;
  logic            rx_resync;
  logic            tx_tick;
  logic            rx_tick;
  logic [OS_W-1:0] rx_os_idx;
  logic            rx_mid;
  logic            cfg_err;
`ifdef UART_CUSTOM_DIV_EN
  logic                       use_custom;
  logic [DIV_W+FRAC_BITS-1:0] custom_div_tx;
  logic [DIV_W+FRAC_BITS-1:0] custom_div_rx;

  modport master (output active, baud_sel, rx_resync, use_custom, custom_div_tx, custom_div_rx,
                  input  tx_tick, rx_tick, rx_os_idx, rx_mid, cfg_err);
  modport slave  (input  active, baud_sel, rx_resync, use_custom, custom_div_tx, custom_div_rx,
                  output tx_tick, rx_tick, rx_os_idx, rx_mid, cfg_err);
`else
  modport master (output active, baud_sel, rx_resync,
                  input  tx_tick, rx_tick, rx_os_idx, rx_mid, cfg_err);
  modport slave  (input  active, baud_sel, rx_resync,
                  output tx_tick, rx_tick, rx_os_idx, rx_mid, cfg_err);
`endif

endinterface

// File: rtl/uart_frac_div.sv
// uart_frac_div: one fractional-N divider channel; tick period alternates
// between I and I+1 cycles so that 2^FRAC_BITS ticks span exactly D cycles.
module uart_frac_div #(
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned FRAC_BITS = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 run,
  input  logic                 clear,
  input  logic [DIV_W-1:0]     int_div,
  input  logic [FRAC_BITS-1:0] frac_div,
  output logic                 tick
);

  logic [DIV_W-1:0]     cnt;
  logic [DIV_W-1:0]     term;
  logic [FRAC_BITS-1:0] acc;
  logic                 ext;

  // ext holds the carry of the previous accumulation and stretches this period.
  assign term = int_div - DIV_W'(1) + DIV_W'(ext);
  assign tick = run && !clear && (cnt == term);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (!run || clear) begin
      cnt <= '0;
      acc <= '0;
      ext <= 1'b0;
    end else if (tick) begin
      cnt        <= '0;
      {ext, acc} <= {1'b0, acc} + {1'b0, frac_div};
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional-N TX (1x) and RX (OVERSAMPLE x) baud tick generator.
// Build option UART_CUSTOM_DIV_EN adds runtime custom divisors in {I,F} format.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned OVERSAMPLE      = 16,
  parameter int unsigned FRAC_BITS       = 4,
  parameter int unsigned DIV_W           = 20
) (
  input logic            clk,
  input logic            arst,
  uart_baud_gen_if.slave bus
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  if (OVERSAMPLE < 4 || OVERSAMPLE > 32 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("uart_baud_gen: OVERSAMPLE must be a power of 2 in 4..32");
  end

  logic [DIV_W-1:0]     tx_i_tbl [16];
  logic [FRAC_BITS-1:0] tx_f_tbl [16];
  logic [DIV_W-1:0]     rx_i_tbl [16];
  logic [FRAC_BITS-1:0] rx_f_tbl [16];

  for (genvar g = 0; g < 16; g++) begin : g_tbl
    localparam div_t TX_D = calc_div(64'(CLOCK_FREQUENCY), 64'(BAUD_RATES[g]), 64'd1, FRAC_BITS);
    localparam div_t RX_D = calc_div(64'(CLOCK_FREQUENCY), 64'(BAUD_RATES[g]),
                                     64'(OVERSAMPLE), FRAC_BITS);
    // The TX integer part is always the largest one, so it bounds DIV_W.
    if (64'(TX_D.int_part) >= (64'd1 << DIV_W)) begin : g_ovf
      $error("uart_baud_gen: divisor for table entry %0d overflows DIV_W", g);
    end
    assign tx_i_tbl[g] = DIV_W'(TX_D.int_part);
    assign tx_f_tbl[g] = FRAC_BITS'(TX_D.frac_part);
    assign rx_i_tbl[g] = DIV_W'(RX_D.int_part);
    assign rx_f_tbl[g] = FRAC_BITS'(RX_D.frac_part);
  end

  baud_sel_t sel_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)             sel_q <= '0;
    else if (!bus.active) sel_q <= bus.baud_sel;
  end

`ifdef UART_CUSTOM_DIV_EN
  logic                       use_q;
  logic [DIV_W+FRAC_BITS-1:0] cust_tx_q;
  logic [DIV_W+FRAC_BITS-1:0] cust_rx_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      use_q     <= 1'b0;
      cust_tx_q <= '0;
      cust_rx_q <= '0;
    end else if (!bus.active) begin
      use_q     <= bus.use_custom;
      cust_tx_q <= bus.custom_div_tx;
      cust_rx_q <= bus.custom_div_rx;
    end
  end
`endif

  logic [DIV_W-1:0]     tx_i;
  logic [DIV_W-1:0]     rx_i;
  logic [FRAC_BITS-1:0] tx_f;
  logic [FRAC_BITS-1:0] rx_f;

  always_comb begin
    tx_i = tx_i_tbl[sel_q];
    tx_f = tx_f_tbl[sel_q];
    rx_i = rx_i_tbl[sel_q];
    rx_f = rx_f_tbl[sel_q];
`ifdef UART_CUSTOM_DIV_EN
    if (use_q) begin
      tx_i = cust_tx_q[FRAC_BITS +: DIV_W];
      tx_f = cust_tx_q[FRAC_BITS-1:0];
      rx_i = cust_rx_q[FRAC_BITS +: DIV_W];
      rx_f = cust_rx_q[FRAC_BITS-1:0];
    end
`endif
  end

  logic cfg_err;
  logic run;
  logic tx_tick;
  logic rx_tick;

  // An integer part below 2 cannot produce a one-cycle-wide tick train.
  assign cfg_err = (tx_i < DIV_W'(2)) || (rx_i < DIV_W'(2));
  assign run     = bus.active && !cfg_err;

  uart_frac_div #(.DIV_W(DIV_W), .FRAC_BITS(FRAC_BITS)) u_tx_div (
    .clk      (clk),
    .arst     (arst),
    .run      (run),
    .clear    (1'b0),
    .int_div  (tx_i),
    .frac_div (tx_f),
    .tick     (tx_tick)
  );

  uart_frac_div #(.DIV_W(DIV_W), .FRAC_BITS(FRAC_BITS)) u_rx_div (
    .clk      (clk),
    .arst     (arst),
    .run      (run),
    .clear    (bus.rx_resync),
    .int_div  (rx_i),
    .frac_div (rx_f),
    .tick     (rx_tick)
  );

  logic [OS_W-1:0] os_idx;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                        os_idx <= '0;
    else if (!run || bus.rx_resync)  os_idx <= '0;
    else if (rx_tick)                os_idx <= os_idx + OS_W'(1);
  end

  assign bus.tx_tick   = tx_tick;
  assign bus.rx_tick   = rx_tick;
  assign bus.rx_os_idx = os_idx;
  assign bus.rx_mid    = rx_tick && (os_idx == OS_W'(OVERSAMPLE / 2 - 1));
  assign bus.cfg_err   = cfg_err;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Fractional-N baud tick generator for the uart_ip TX and RX engines; successor to the fixed integer clock-enable generator.
- Two independent divider channels: TX at 1x baud and RX at OVERSAMPLE x baud.
- Each channel uses an integer counter plus a FRAC_BITS phase accumulator, so the average tick period is exact to 1/2^FRAC_BITS of a clock cycle.
- The RX channel can be re-phased on a start-bit edge (rx_resync) and exports its oversample index for mid-bit sampling.

Parameters:
- CLOCK_FREQUENCY, 50_000_000: input clock frequency in Hz.
- OVERSAMPLE, 16: RX ticks per bit; must be a power of 2, range 4..32.
- FRAC_BITS, 4: width of the fractional accumulator.
- DIV_W, 20: width of the integer-part counter; elaboration error if the slowest rate overflows it.

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- active  in  1  enables tick generation; when low, both channels idle
- baud_sel  in  4  index into the 16-entry baud table (200 … 460800 bps)
- rx_resync  in  1  one-cycle pulse on the detected start-bit falling edge; restarts RX phase
- tx_tick  out  1  one-cycle pulse per TX bit period
- rx_tick  out  1  one-cycle pulse per RX oversample period
- rx_os_idx  out  $clog2(OVERSAMPLE)  oversample index within the current RX bit; incremented on each rx_tick
- rx_mid  out  1  equals rx_tick AND rx_os_idx == OVERSAMPLE/2-1
- cfg_err  out  1  selected divisor integer part < 2; ticks suppressed while set

Behaviour:
- Divisor constants, computed at elaboration in 64-bit arithmetic with round-half-up: D = (CLK·2^FB + den/2)/den.
  - TX: den = BAUD.
  - RX: den = BAUD·OVERSAMPLE.
  - I = D >> FB; F = D mod 2^FB.
- Per channel (sub-module): registers cnt[DIV_W], acc[FB], ext (1 bit). term = I − 1 + ext.
  - tick = run && cnt == term, decoded combinationally from registers.
  - On tick: cnt <= 0; {ext, acc} <= acc + F, where ext is the carry out.
  - Otherwise: cnt <= cnt + 1.
  - Resulting period is I or I+1 cycles; over every 2^FB ticks the total is exactly D cycles.
- Configuration latch: baud_sel is registered into sel_q only while active == 0. Changes while active == 1 are ignored until active falls.
- Activation: active low → cnt, acc, ext, rx_os_idx are cleared on the next edge and ticks are 0 in the same cycle. The first tick after active rises (edge E) occurs I cycles after E.
- rx_resync while active, RX channel only:
  - Next edge: cnt <= 0, acc <= 0, ext <= 0, rx_os_idx <= 0.
  - rx_tick is suppressed in the resync cycle even if cnt == term.
  - The TX channel is unaffected.
- rx_os_idx wraps from OVERSAMPLE−1 to 0.
- cfg_err = (I_tx < 2) || (I_rx < 2) for sel_q. While set, run = 0, so no ticks are produced and counters are held at 0.
- Reset (arst): all counters, accumulators and ext cleared; sel_q = 0; rx_os_idx = 0; all tick outputs 0.
- Reset asserted mid-period aborts the period with no partial tick.
- Simultaneous active fall and rx_resync: clearing wins and the outcome is identical.

Optional Feature:
- Macro: UART_CUSTOM_DIV_EN.
- Defined: adds input ports use_custom (1 bit), custom_div_tx and custom_div_rx (DIV_W+FRAC_BITS bits each, in {I,F} format).
  - When use_custom is latched high (latched like baud_sel, only while active == 0), the custom divisors replace the table values.
  - cfg_err applies to the custom values as well.
- Undefined: these ports do not exist and only table rates are available.

Decomposition:
- Package uart_pkg holds:
  - the BAUD_RATES[16] constant;
  - function calc_div(clk, baud, os, fb), returning {I,F};
  - typedef baud_sel_t (logic [3:0]);
  - typedef div_t (struct: int_part, frac_part).
- Sub-module uart_frac_div (one channel: cnt/acc/ext, run, clear, I, F → tick), instantiated twice.
- The top level adds the sel latch, rx_os_idx, rx_mid and cfg_err.

Test Plan:
- 50 MHz, sel = 9600 (RX: D = 5208, I = 325, F = 8): periods alternate 325/326 cycles; 16 rx_ticks span exactly 5208 cycles; rx_mid on the 8th tick (idx 7).
- TX at 9600 (D = 83333, I = 5208, F = 5): 16 consecutive tx_ticks total 83333 cycles; each period is 5208 or 5209 cycles.
- sel = 460800 (RX I = 6, F = 13; TX I = 108, F = 8): cfg_err = 0; sums over 16 periods are 109 cycles (RX, rounded from 108.5) and 1736 cycles (TX).
- rx_resync pulse at RX cnt = 200 (9600): no rx_tick that cycle; next rx_tick exactly 325 cycles later; rx_os_idx = 0; tx_tick timing unchanged.
- Change baud_sel while active = 1: tick rate is unchanged; after an active 1→0→1 cycle the new rate applies, with the first tick I cycles after activation.
- arst asserted mid-period: all outputs 0 immediately. UART_CUSTOM_DIV_EN build with custom_div_rx = {1, 0}: cfg_err = 1 and no ticks.
